// File: rtl/arbiter_out_fifo.sv
// arbiter_out_fifo
// Valid/ready FIFO placed directly after the arbiter. It absorbs sink
// back-pressure for up to DEPTH beats so arbitration can keep granting,
// and reports occupancy plus a high-water mark for bring-up/debug.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   valid_in   upstream beat valid (arbiter valid_out)
//   data_in    upstream beat data (arbiter data_out)
//   ready_out  FIFO can accept a beat (arbiter ready_in)
//   valid_out  head entry valid toward the sink
//   data_out   head entry data, zero when empty (show-ahead)
//   ready_in   sink ready
//   count      current occupancy, 0..DEPTH
//   max_count  highest occupancy seen since reset
//   full       count == DEPTH
//   empty      count == 0
module arbiter_out_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  output logic          ready_out,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  input  logic          ready_in,
  output logic [CW-1:0] count,
  output logic [CW-1:0] max_count,
  output logic          full,
  output logic          empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] max_count_r;
  logic [CW-1:0] count_nxt_s;
  logic          push_s;
  logic          pop_s;

  // Flags decode the occupancy register, never the pointers. ready_out
  // depends only on full and rst, so a same-cycle pop cannot reopen it.
  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign ready_out = ~full & ~rst;
  assign valid_out = ~empty;
  assign data_out  = valid_out ? mem_r[rd_ptr_r] : {DW{1'b0}};
  assign count     = count_r;
  assign max_count = max_count_r;

  assign push_s = valid_in & ready_out;
  assign pop_s  = valid_out & ready_in;

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; deliberately not reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy and high-water mark. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      max_count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      if (count_nxt_s > max_count_r) begin
        max_count_r <= count_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_out_fifo.sv
module tb_arbiter_out_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;
  logic [CW-1:0] count;
  logic [CW-1:0] max_count;
  logic          full;
  logic          empty;

  arbiter_out_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .ready_in(ready_in), .count(count), .max_count(max_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered queue of accepted bytes plus the peak size.
  logic [7:0] q[$];
  int         mmax = 0;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       ri;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    int         e_cnt;
    int         e_max;
    logic       e_full;
    logic       e_empty;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic ri,
                              input logic e_rdy, input logic e_vld, input logic [7:0] e_dat,
                              input int e_cnt, input int e_max, input logic e_full, input logic e_empty);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.ri = ri;
    x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_dat = e_dat;
    x.e_cnt = e_cnt; x.e_max = e_max; x.e_full = e_full; x.e_empty = e_empty;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic ri);
    rst = r; valid_in = v; data_in = d; ready_in = ri;
    #1;
  endtask

  // Compare every output against the queue model for the current cycle.
  task automatic check_model(input string tag);
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    e_rdy = !rst && (q.size() < DEPTH);
    e_vld = (q.size() > 0);
    e_dat = e_vld ? q[0] : 8'h00;
    chk({tag, "_ready_out"}, {31'd0, ready_out}, {31'd0, e_rdy});
    chk({tag, "_valid_out"}, {31'd0, valid_out}, {31'd0, e_vld});
    chk({tag, "_data_out"},  {24'd0, data_out},  {24'd0, e_dat});
    chk({tag, "_count"},     {29'd0, count},     q.size());
    chk({tag, "_max_count"}, {29'd0, max_count}, mmax);
    chk({tag, "_full"},      {31'd0, full},      {31'd0, (q.size() == DEPTH)});
    chk({tag, "_empty"},     {31'd0, empty},     {31'd0, (q.size() == 0)});
  endtask

  // Clock edge: update the model from the inputs held across the edge.
  task automatic advance();
    logic       pop_m;
    logic       push_m;
    logic       r_m;
    logic [7:0] d_m;
    pop_m  = (q.size() > 0) && ready_in && !rst;
    push_m = valid_in && !rst && (q.size() < DEPTH);
    r_m    = rst;
    d_m    = data_in;
    @(posedge clk);
    if (r_m) begin
      q.delete();
      mmax = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(d_m);
      if (q.size() > mmax) mmax = q.size();
    end
    #1;
  endtask

  initial begin
    // Reset, then streaming, fill/back-pressure and full-with-pop.
    tbl[0]  = mk(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h21, 1, 1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 8'h65, 1'b1, 1'b1, 1'b1, 8'h43, 1, 1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 8'h87, 1'b1, 1'b1, 1'b1, 8'h65, 1, 1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h87, 1, 1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1, 1, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2, 2, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3, 3, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4, 4, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4, 4, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 4, 4, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3, 4, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03, 3, 4, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3, 4, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 2, 4, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 1, 4, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 4, 1'b0, 1'b1);

    // Bring the DUT out of its unknown power-up state before checking.
    drive(1'b1, 1'b1, 8'h99, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ri);
      check_model($sformatf("row%0d_model", i));
      chk($sformatf("row%0d_ready_out", i), {31'd0, ready_out}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("row%0d_valid_out", i), {31'd0, valid_out}, {31'd0, tbl[i].e_vld});
      chk($sformatf("row%0d_data_out", i),  {24'd0, data_out},  {24'd0, tbl[i].e_dat});
      chk($sformatf("row%0d_count", i),     {29'd0, count},     tbl[i].e_cnt);
      chk($sformatf("row%0d_max_count", i), {29'd0, max_count}, tbl[i].e_max);
      chk($sformatf("row%0d_full", i),      {31'd0, full},      {31'd0, tbl[i].e_full});
      chk($sformatf("row%0d_empty", i),     {31'd0, empty},     {31'd0, tbl[i].e_empty});
      advance();
    end

    // Random soak with an incrementing byte pattern; many pointer wraps.
    begin
      logic [7:0] nxt;
      logic       v;
      logic       ri;
      nxt = 8'h00;
      for (int c = 0; c < 200; c++) begin
        v  = ($urandom_range(0, 3) != 0);
        ri = ($urandom_range(0, 2) != 0);
        drive(1'b0, v, nxt, ri);
        check_model($sformatf("soak%0d", c));
        if (v && (q.size() < DEPTH)) nxt = nxt + 8'h01;
        advance();
      end
    end

    // Drain, bounded by a cycle budget.
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_model("drain");
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Reset mid-operation at count = 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h11 + 8'(i), 1'b0);
      advance();
    end
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    chk("mid_pre_count", {29'd0, count}, 32'd3);
    chk("mid_pre_valid", {31'd0, valid_out}, 32'd1);
    chk("mid_pre_ready", {31'd0, ready_out}, 32'd0);
    advance();
    drive(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("mid_post_count", {29'd0, count}, 32'd0);
    chk("mid_post_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_post_max", {29'd0, max_count}, 32'd0);
    chk("mid_post_ready", {31'd0, ready_out}, 32'd1);
    check_model("mid_post");
    advance();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_first_valid", {31'd0, valid_out}, 32'd1);
    chk("mid_first_data", {24'd0, data_out}, 32'hAA);
    check_model("mid_first");
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_out_fifo.md
# arbiter_out_fifo

Parameterized valid/ready FIFO that sits directly downstream of `arbiter` and buffers its granted output stream before the sink. It decouples sink back-pressure from arbitration, so the arbiter keeps granting while the sink stalls for up to DEPTH beats. It also reports occupancy and a high-water mark for bring-up and debug.

## Interface

Parameters:
- `DW`, default 8, data width; must equal the arbiter's `DW`.
- `DEPTH`, default 4, number of entries; a power of two, minimum 2.
- `CW`, default `$clog2(DEPTH+1)`, width of `count` and `max_count`.

Ports:
- `clk`, input, 1, single clock; all logic is rising-edge.
- `rst`, input, 1, synchronous, active-high reset.
- `valid_in`, input, 1, upstream beat valid; connects to the arbiter's `valid_out`.
- `data_in`, input, DW, upstream data; connects to the arbiter's `data_out`.
- `ready_out`, output, 1, FIFO can accept a beat; connects to the arbiter's `ready_in`.
- `valid_out`, output, 1, head entry valid toward the sink.
- `data_out`, output, DW, head entry data.
- `ready_in`, input, 1, sink ready.
- `count`, output, CW, current occupancy, 0 to DEPTH.
- `max_count`, output, CW, highest occupancy seen since reset.
- `full`, output, 1, asserted when `count == DEPTH`.
- `empty`, output, 1, asserted when `count == 0`.

## Operation

- **Storage**
  - DEPTH x DW register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)` bits; each wraps naturally from DEPTH-1 to 0.
  - `count` is a separate register, not derived from the pointers.
- **Push:** `push = valid_in & ready_out`.
  - Writes `data_in` to `mem[wr_ptr]` and increments `wr_ptr`.
- **Pop:** `pop = valid_out & ready_in`.
  - Increments `rd_ptr`.
- **Count update:**
  - `count` +1 on push only.
  - `count` -1 on pop only.
  - `count` unchanged on push and pop together, or on neither.
- **Flow control:**
  - `ready_out = ~full & ~rst`.
  - When full, a pop in the same cycle does NOT open `ready_out`; there is no combinational ready-in to ready-out path.
  - `valid_out = ~empty`.
- **Head data:** `data_out = valid_out ? mem[rd_ptr] : 0`. This is show-ahead: the head is visible without a pop.
- **High-water mark:** `max_count` updates to the next-cycle `count` value whenever that value exceeds the current `max_count`.
- **Status flags:** `full` and `empty` are combinational decodes of `count`.
- **Illegal stimulus:** `valid_in` asserted while `ready_out` is low is ignored. Data is not written and the upstream must hold the beat.
- **Ordering:** strict FIFO. No reordering, no drops, no duplication.

## Timing

- **Reset (rst high at a clock edge):** at the next edge `count = 0`, `max_count = 0`, and both pointers are 0.
  - `valid_out = 0`, `data_out = 0`, `empty = 1`, `full = 0`.
  - `ready_out = 0` for the whole time `rst` is high, then 1 in the first cycle after reset is released.
  - The memory array is not reset.
- **Reset mid-operation:** all buffered beats are discarded.
  - `valid_out` drops in the cycle after the reset edge.
  - No beat is popped at that edge.
- **Latency:** one cycle, no bypass. A beat pushed at edge N is presented on `valid_out`/`data_out` after edge N. At the earliest it can be popped at edge N+1.
- **Throughput:** one beat per cycle when neither side stalls, including simultaneous push and pop at any `count` from 1 to DEPTH-1.
- **Empty boundary:** a push alone is accepted. A pop is impossible because `valid_out` is 0.
- **Full boundary:** a push is blocked. A pop at edge N drops `count` to DEPTH-1, so `ready_out` rises after edge N.
- **Wrap-around:** the pointers wrap with no bubble. Data integrity must hold across at least 3 complete wraps.
- **Counter widths:** `count` and `max_count` never exceed DEPTH. No overflow is possible at CW bits.

## Test plan

1. **Reset values.** Hold `rst` for 2 cycles with `valid_in = 1`.
   - Required: `ready_out = 0`, `valid_out = 0`, `data_out = 0`, `count = 0`, `empty = 1` throughout.
   - After release: `ready_out = 1`.
2. **Streaming.** Upstream sends 0x21, 0x43, 0x65, 0x87 on back-to-back cycles with `ready_in = 1`.
   - Required: the sink sees the same four bytes in order, each one cycle after its push.
   - `count` stays at most 1, and `max_count = 1`.
3. **Fill and back-pressure.** `ready_in = 0`, upstream sends 6 beats 0x01 to 0x06 (DEPTH = 4).
   - Required: `full = 1` with `count = 4`, and `ready_out` drops after the 4th push.
   - Beats 0x05 and 0x06 are held upstream.
   - Raise `ready_in`: the output is 0x01 to 0x06 in order, and `max_count = 4`.
4. **Full with simultaneous pop.** At `count = 4`, assert `ready_in` and `valid_in` together.
   - Required: in that cycle the pop occurs and the push does not.
   - `count` becomes 3 and `ready_out` becomes 1 in the next cycle.
5. **Wrap-around soak.** Random `valid_in`/`ready_in` over 200 cycles with an incrementing byte pattern.
   - Required: the scoreboard matches every byte, with no loss or duplicate.
   - `count` always equals pushes minus pops.
6. **Reset mid-operation.** Assert `rst` for 1 cycle at `count = 3`.
   - Required: after the reset edge, `count = 0`, `valid_out = 0`, and `max_count = 0`.
   - The next push of 0xAA is the first byte out.
